mailbox_msg_reader: RTL and testbench

Consumer-side engine for the mailbox register store. It takes a doorbell plus a message length from the writer side. It then walks the mailbox read port (rd/rd_sel, rdata/rvalid returned combinationally in the same cycle) word by word, and streams the words out on a valid/ready interface with a last flag. When the message has been fully drained it acknowledges back to the writer, so software or the fabric can post the next message.

---
 rtl/mbx_pkg.sv | 26 ++
 rtl/mailbox_msg_reader_if.sv | 14 +
 rtl/mbx_out_reg.sv | 39 +++
 rtl/mailbox_msg_reader.sv | 166 ++++++++++++++++
 tb/tb_mailbox_msg_reader.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mbx_pkg.sv
// Shared types and widths for the mailbox engines.
// Latency: none, declarations only.
// Backpressure: not applicable.
package mbx_pkg;

    localparam int MBX_MAX_DEPTH = 8;
    localparam int MBX_SEL_W     = 4;
    localparam int MBX_DATA_W    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        ACK   = 2'd3
    } state_t;

    // Index of the final word of a message.
    // The length is clamped to the mailbox depth first.
    // Only meaningful for len >= 1.
    function automatic logic [MBX_SEL_W-1:0] last_index(input int len, input int depth);
        int n;
        n = (len > depth) ? depth : len;
        return MBX_SEL_W'(n - 1);
    endfunction

endpackage

// File: rtl/mailbox_msg_reader_if.sv
// Outbound word stream of the mailbox reader (data, valid/ready, last).
// Latency: none, wires only.
// Backpressure: the consumer holds m_tready low to stall the producer.
interface mailbox_msg_reader_if;
    import mbx_pkg::*;

    logic [MBX_DATA_W-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/mbx_out_reg.sv
// One-entry valid/ready output register carrying a data word plus a last flag.
// Latency: 1 cycle from load to out_vld.
// Backpressure: holds data/last stable while out_rdy is low; free reports room for a load.
module mbx_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    input  logic         load_last,
    output logic         free,
    output logic         accept,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat,
    output logic         out_last
);

    // The slot can take a new word when empty or when it empties this cycle.
    assign free   = !out_vld || out_rdy;
    assign accept = out_vld && out_rdy;

    // Load has priority: a load in the same cycle as a handshake replaces the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_last <= 1'b0;
        end else if (load) begin
            out_vld  <= 1'b1;
            out_dat  <= load_dat;
            out_last <= load_last;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/mailbox_msg_reader.sv
// Mailbox reader: on a doorbell, walks the mailbox and streams the message out, then acks.
// Latency: doorbell at N -> mbx_rd at N+1, first beat at N+2, msg_ack 1 cycle after the last beat.
// Backpressure: m_tready low stalls mailbox reads; one extra doorbell is queued, further ones set ovf_err.
// Optional: define MBX_READER_CSUM_EN to add the msg_csum output (sum of the message words).
module mailbox_msg_reader
    import mbx_pkg::*;
#(
    parameter int MESSAGE_DEPTH = 1,
    parameter int LEN_W         = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  doorbell,
    input  logic [LEN_W-1:0]      msg_len,
    output logic                  mbx_rd,
    output logic [MBX_SEL_W-1:0]  mbx_rd_sel,
    input  logic [MBX_DATA_W-1:0] mbx_rdata,
    input  logic                  mbx_rvalid,
    mailbox_msg_reader_if.master  strm,
    output logic                  msg_ack,
    output logic                  busy,
    input  logic                  err_clr,
    output logic                  len_err,
    output logic                  rd_err,
    output logic                  ovf_err
`ifdef MBX_READER_CSUM_EN
    ,
    output logic [MBX_DATA_W-1:0] msg_csum
`endif
);

    localparam int EFF_DEPTH = (MESSAGE_DEPTH > MBX_MAX_DEPTH) ? MBX_MAX_DEPTH : MESSAGE_DEPTH;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(EFF_DEPTH);

    state_t               state;
    logic [MBX_SEL_W-1:0] idx_q;
    logic [MBX_SEL_W-1:0] last_q;
    logic                 pend_q;
    logic [LEN_W-1:0]     pend_len_q;

    logic                 out_free;
    logic                 out_accept;
    logic                 start;
    logic [LEN_W-1:0]     start_len;
    logic                 start_zero;
    logic                 start_big;

    // A queued doorbell is always served before a fresh one.
    assign start      = (state == IDLE) && (pend_q || doorbell);
    assign start_len  = pend_q ? pend_len_q : msg_len;
    assign start_zero = (start_len == '0);
    assign start_big  = (start_len > DEPTH_L);

    // Reads depend on this cycle's m_tready, so the strobe is decoded from state.
    assign mbx_rd     = (state == READ) && out_free;
    assign mbx_rd_sel = mbx_rd ? idx_q : '0;
    assign busy       = (state != IDLE) || pend_q;

    mbx_out_reg #(
        .W (MBX_DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (mbx_rd),
        .load_dat  (mbx_rdata),
        .load_last (idx_q == last_q),
        .free      (out_free),
        .accept    (out_accept),
        .out_vld   (strm.m_tvalid),
        .out_rdy   (strm.m_tready),
        .out_dat   (strm.m_tdata),
        .out_last  (strm.m_tlast)
    );

    // Message sequencer, pending doorbell slot, sticky errors and the optional checksum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            pend_q     <= 1'b0;
            pend_len_q <= '0;
            msg_ack    <= 1'b0;
            len_err    <= 1'b0;
            rd_err     <= 1'b0;
            ovf_err    <= 1'b0;
`ifdef MBX_READER_CSUM_EN
            msg_csum   <= '0;
`endif
        end else begin
            // Clear first so that an error event later in this block wins.
            if (err_clr) begin
                len_err <= 1'b0;
                rd_err  <= 1'b0;
                ovf_err <= 1'b0;
            end

            // In IDLE the slot drains into the sequencer and may refill from a
            // simultaneous doorbell; elsewhere a doorbell fills it or overflows.
            if (state == IDLE) begin
                if (pend_q) begin
                    pend_q <= doorbell;
                    if (doorbell) begin
                        pend_len_q <= msg_len;
                    end
                end
            end else if (doorbell) begin
                if (pend_q) begin
                    ovf_err <= 1'b1;
                end else begin
                    pend_q     <= 1'b1;
                    pend_len_q <= msg_len;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        idx_q  <= '0;
                        last_q <= last_index(int'(start_len), EFF_DEPTH);
`ifdef MBX_READER_CSUM_EN
                        msg_csum <= '0;
`endif
                        if (start_zero || start_big) begin
                            len_err <= 1'b1;
                        end
                        // An empty message goes straight to ACK; ACK then
                        // spends one cycle raising msg_ack.
                        state <= start_zero ? ACK : READ;
                    end
                end
                READ: begin
                    if (mbx_rd) begin
                        idx_q <= idx_q + MBX_SEL_W'(1);
                        if (!mbx_rvalid) begin
                            rd_err <= 1'b1;
                        end
`ifdef MBX_READER_CSUM_EN
                        msg_csum <= msg_csum + mbx_rdata;
`endif
                        if (idx_q == last_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Only the final word can be in the register here.
                    if (out_accept && strm.m_tlast) begin
                        state   <= ACK;
                        msg_ack <= 1'b1;
                    end
                end
                ACK: begin
                    if (msg_ack) begin
                        msg_ack <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        msg_ack <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mailbox_msg_reader.sv
// Directed bench for mailbox_msg_reader with a beat/ack scoreboard and stream monitor.
// Latency: checks the doorbell->beat and last-beat->ack timing where it is fixed.
// Backpressure: drives a stalling m_tready pattern and checks stream stability.
module tb_mailbox_msg_reader;
    import mbx_pkg::*;

    logic                  clk       = 1'b0;
    logic                  reset     = 1'b1;
    logic                  doorbell  = 1'b0;
    logic [3:0]            msg_len   = '0;
    logic                  err_clr   = 1'b0;
    logic                  mbx_rd;
    logic [MBX_SEL_W-1:0]  mbx_rd_sel;
    logic [MBX_DATA_W-1:0] mbx_rdata;
    logic                  mbx_rvalid;
    logic                  msg_ack;
    logic                  busy;
    logic                  len_err;
    logic                  rd_err;
    logic                  ovf_err;
`ifdef MBX_READER_CSUM_EN
    logic [MBX_DATA_W-1:0] msg_csum;
`endif

    mailbox_msg_reader_if strm();

    mailbox_msg_reader #(
        .MESSAGE_DEPTH (4),
        .LEN_W         (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .doorbell   (doorbell),
        .msg_len    (msg_len),
        .mbx_rd     (mbx_rd),
        .mbx_rd_sel (mbx_rd_sel),
        .mbx_rdata  (mbx_rdata),
        .mbx_rvalid (mbx_rvalid),
        .strm       (strm),
        .msg_ack    (msg_ack),
        .busy       (busy),
        .err_clr    (err_clr),
        .len_err    (len_err),
        .rd_err     (rd_err),
        .ovf_err    (ovf_err)
`ifdef MBX_READER_CSUM_EN
        ,
        .msg_csum   (msg_csum)
`endif
    );

    // Mailbox model: combinational read port, optional invalid index.
    logic [31:0] mem [8];
    logic        bad_en  = 1'b0;
    logic [3:0]  bad_idx = '0;
    assign mbx_rvalid = !(bad_en && (mbx_rd_sel == bad_idx));
    assign mbx_rdata  = mbx_rvalid ? mem[mbx_rd_sel[2:0]] : 32'h0;

    int checks   = 0;
    int passes   = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int beat_cnt = 0;

    typedef struct { logic [31:0] dat; logic last; int at; } beat_t;
    typedef struct { int at; logic [31:0] csum; } ack_t;
    beat_t exp_q[$];
    ack_t  ack_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops the scoreboard on every handshake/ack and watches stream rules.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_dat   = '0;
    logic        prev_last  = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_tvalid", 32'(strm.m_tvalid), 32'd1);
                chk("stall_tdata", strm.m_tdata, prev_dat);
                chk("stall_tlast", 32'(strm.m_tlast), 32'(prev_last));
            end
            if (strm.m_tvalid && !strm.m_tready) chk("rd_while_full", 32'(mbx_rd), 32'd0);
            if (mbx_rd) rd_cnt++;
            if (strm.m_tvalid && strm.m_tready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL beat_unexpected: got data 0x%0h, expected no beat (cycle %0d)", strm.m_tdata, cyc);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", strm.m_tdata, e.dat);
                    chk("beat_last", 32'(strm.m_tlast), 32'(e.last));
                    if (e.at >= 0) chk("beat_cycle", 32'(cyc), 32'(e.at));
                end
            end
            if (msg_ack) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    $display("FAIL ack_unexpected: got msg_ack, expected none (cycle %0d)", cyc);
                end else begin
                    ack_t a;
                    a = ack_q.pop_front();
                    if (a.at >= 0) chk("ack_cycle", 32'(cyc), 32'(a.at));
`ifdef MBX_READER_CSUM_EN
                    chk("ack_csum", msg_csum, a.csum);
`endif
                end
            end
            stall_prev = strm.m_tvalid && !strm.m_tready;
            prev_dat   = strm.m_tdata;
            prev_last  = strm.m_tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ring(input logic [3:0] len);
        doorbell = 1'b1;
        msg_len  = len;
        tick();
        doorbell = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic l, input int at);
        exp_q.push_back('{d, l, at});
    endtask

    task automatic ack(input int at, input logic [31:0] cs);
        ack_q.push_back('{at, cs});
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic drained(input string name);
        chk({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_acks_left"}, 32'(ack_q.size()), 32'd0);
    endtask

    // Four words 0x11..0x44, tready high, exact timing.
    task automatic std_msg(input string name);
        int n;
        n = cyc;
        beat(32'h11, 1'b0, n + 2);
        beat(32'h22, 1'b0, n + 3);
        beat(32'h33, 1'b0, n + 4);
        beat(32'h44, 1'b1, n + 5);
        ack(n + 6, 32'hAA);
        ring(4'd4);
        repeat (8) tick();
        chk({name, "_len_err"}, 32'(len_err), 32'd0);
        chk({name, "_rd_err"}, 32'(rd_err), 32'd0);
        chk({name, "_ovf_err"}, 32'(ovf_err), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        drained(name);
    endtask

    logic [3:0] pat = 4'b1001;

    initial begin
        int n;
        int rd0;
        int b0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h11 * (i + 1);
        strm.m_tready = 1'b1;

        // Reset state
        #3;
        chk("rst_tvalid", 32'(strm.m_tvalid), 32'd0);
        chk("rst_tdata", strm.m_tdata, 32'd0);
        chk("rst_tlast", 32'(strm.m_tlast), 32'd0);
        chk("rst_mbx_rd", 32'(mbx_rd), 32'd0);
        chk("rst_ack", 32'(msg_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_errs", {29'd0, len_err, rd_err, ovf_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // Plain four-word message
        std_msg("s1");

        // Stalling consumer
        rd0 = rd_cnt;
        beat(32'h11, 1'b0, -1);
        beat(32'h22, 1'b0, -1);
        beat(32'h33, 1'b0, -1);
        beat(32'h44, 1'b1, -1);
        ack(-1, 32'hAA);
        for (int i = 0; i < 24; i++) begin
            strm.m_tready = pat[i % 4];
            doorbell      = (i == 0);
            msg_len       = 4'd4;
            tick();
        end
        doorbell      = 1'b0;
        strm.m_tready = 1'b1;
        repeat (4) tick();
        chk("s2_reads", 32'(rd_cnt - rd0), 32'd4);
        drained("s2");

        // Zero length
        rd0 = rd_cnt;
        b0  = beat_cnt;
        n   = cyc;
        ack(n + 2, 32'h0);
        ring(4'd0);
        repeat (5) tick();
        chk("s3_zero_reads", 32'(rd_cnt - rd0), 32'd0);
        chk("s3_zero_beats", 32'(beat_cnt - b0), 32'd0);
        chk("s3_zero_len_err", 32'(len_err), 32'd1);
        clear_errs();
        chk("s3_len_err_clr", 32'(len_err), 32'd0);
        drained("s3a");

        // Oversize length clamps to depth 4
        rd0 = rd_cnt;
        n   = cyc;
        beat(32'h11, 1'b0, n + 2);
        beat(32'h22, 1'b0, n + 3);
        beat(32'h33, 1'b0, n + 4);
        beat(32'h44, 1'b1, n + 5);
        ack(n + 6, 32'hAA);
        ring(4'd7);
        repeat (8) tick();
        chk("s3_big_len_err", 32'(len_err), 32'd1);
        chk("s3_big_reads", 32'(rd_cnt - rd0), 32'd4);
        drained("s3b");
        clear_errs();

        // Pending doorbell then overflow
        n = cyc;
        beat(32'h11, 1'b0, n + 2);
        beat(32'h22, 1'b0, n + 3);
        beat(32'h33, 1'b0, n + 4);
        beat(32'h44, 1'b1, n + 5);
        ack(n + 6, 32'hAA);
        beat(32'h11, 1'b0, n + 9);
        beat(32'h22, 1'b1, n + 10);
        ack(n + 11, 32'h33);
        ring(4'd4);
        tick();
        doorbell = 1'b1;
        msg_len  = 4'd2;
        tick();
        msg_len  = 4'd3;
        tick();
        doorbell = 1'b0;
        chk("s4_ovf_err", 32'(ovf_err), 32'd1);
        repeat (3) tick();
        chk("s4_busy_pending", 32'(busy), 32'd1);
        repeat (3) tick();
        chk("s4_busy_second", 32'(busy), 32'd1);
        repeat (2) tick();
        chk("s4_busy_done", 32'(busy), 32'd0);
        repeat (3) tick();
        drained("s4");
        clear_errs();
        chk("s4_ovf_clr", 32'(ovf_err), 32'd0);

        // Invalid read on index 2
        bad_en  = 1'b1;
        bad_idx = 4'd2;
        n = cyc;
        beat(32'h11, 1'b0, n + 2);
        beat(32'h22, 1'b0, n + 3);
        beat(32'h00, 1'b0, n + 4);
        beat(32'h44, 1'b1, n + 5);
        ack(n + 6, 32'h77);
        ring(4'd4);
        repeat (8) tick();
        bad_en = 1'b0;
        chk("s5_rd_err", 32'(rd_err), 32'd1);
        clear_errs();
        chk("s5_rd_err_clr", 32'(rd_err), 32'd0);
        drained("s5");

        // Reset mid-message
        n = cyc;
        beat(32'h11, 1'b0, n + 2);
        ring(4'd4);
        tick();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("s6_tvalid", 32'(strm.m_tvalid), 32'd0);
        chk("s6_tdata", strm.m_tdata, 32'd0);
        chk("s6_tlast", 32'(strm.m_tlast), 32'd0);
        chk("s6_mbx_rd", 32'(mbx_rd), 32'd0);
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_ack", 32'(msg_ack), 32'd0);
        drained("s6_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        std_msg("s6_after");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
